pipe_credit_fifo: RTL and testbench
===================================

PIPE_CREDIT_FIFO -- requirements
Module: pipe_credit_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data width, matching the WIDTH of the upstream delay line.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of 2, at least 2.
REQ-003 Parameter LATENCY, default 4: at least 1; equals the CYCLES of the upstream delay line this block terminates.
REQ-004 clk  in  1  clock; all state on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  producer offers an item to the delay-line input this cycle.
REQ-007 in_ready  out  1  credit available; the item is accepted when in_valid and in_ready are both 1.
REQ-008 pipe_en  out  1  enable driven to every stage of the upstream delay line.
REQ-009 pipe_data  in  WIDTH  delay-line output.
REQ-010 out_valid  out  1  FIFO head valid (show-ahead).
REQ-011 out_ready  in  1  consumer pops the head when out_valid and out_ready are both 1.
REQ-012 out_data  out  WIDTH  FIFO head data; don't-care when out_valid=0.
REQ-013 count  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-014 stall_cycles  out  16  back-pressure statistic; present only under the configuration macro.

Function
REQ-015 Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready; inflight = number of set bits in a LATENCY-bit valid chain v[0..LATENCY-1], held as a registered counter.
REQ-016 in_ready SHALL be (count + inflight) < DEPTH, computed only from registered state, with no combinational path from in_valid or out_ready.
REQ-017 pipe_en SHALL be accept | (inflight != 0); the delay line advances only while data is entering or in flight.
REQ-018 When pipe_en=1, the valid chain SHALL shift: v[0] <= accept, v[i] <= v[i-1]; when pipe_en=0, the chain holds.
REQ-019 Push SHALL occur on any cycle with v[LATENCY-1]=1, writing pipe_data into the FIFO tail.
REQ-020 Latency: an item accepted in cycle 0 into an empty system SHALL appear with out_valid=1 in cycle LATENCY+1, with data unchanged.
REQ-021 Ordering SHALL be strict FIFO; no item is dropped or duplicated.
REQ-022 count SHALL update as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-023 Empty: out_valid=0 and out_ready is ignored. A push into an empty FIFO is visible at the head the next cycle (no bypass).
REQ-024 Full: the credit rule guarantees no push while count=DEPTH; a push while full is a design error and the bench SHALL flag it.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 Invariant: count + inflight <= DEPTH in every cycle.
REQ-027 With out_ready held at 0, at most DEPTH items SHALL be accepted, after which in_ready=0 until a pop occurs.
REQ-028 A pop SHALL free a credit, raising in_ready in the following cycle.

Reset
REQ-029 On rst: v=0, inflight=0, count=0, pointers=0, out_valid=0, in_ready=1, pipe_en=0, stall_cycles=0.
REQ-030 rst asserted mid-operation SHALL discard all in-flight and stored items; the delay line shares the same rst.
REQ-031 FIFO storage array is not reset; out_data is don't-care after reset.

Configuration
REQ-032 Macro PIPE_CREDIT_FIFO_STATS_EN.
- Defined: stall_cycles increments on each cycle with in_valid=1 and in_ready=0, saturates at 16'hFFFF, and is cleared only by rst.
- Undefined: the stall_cycles port and its counter are absent; all other behaviour is identical.

Verification
REQ-033 LATENCY=4, DEPTH=8, in_valid=1 for cycle 0 only with the delay line holding data 8'hA5 -> out_valid=1 in cycle 5 with out_data=8'hA5, then pipe_en=0 once drained.
REQ-034 out_ready=0, in_valid held high -> exactly 8 accepts, in_ready=0 afterwards, count reaches 8, no push while full.
REQ-035 From the full state, out_ready=1 for one cycle -> count=7, in_ready=1 the next cycle, one further accept, count returns to 8 after LATENCY+1 cycles.
REQ-036 Continuous in_valid and out_ready with 20 incrementing items 0..19 -> output sequence 0..19 in order, with throughput of 1 item per cycle after fill.
REQ-037 rst pulsed while 3 items are in flight and 2 are stored -> count=0, out_valid=0, in_ready=1; no stale item emerges afterwards.
REQ-038 With the macro defined, in_valid=1 for 5 cycles while in_ready=0 -> stall_cycles=5; with the counter preloaded to 16'hFFFE and 3 stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/pipe_credit_fifo.sv
// Credit-based terminator for a fixed-latency delay line feeding a show-ahead FIFO.
// Optional back-pressure statistic: define PIPE_CREDIT_FIFO_STATS_EN to add stall_cycles.
module pipe_credit_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         pipe_en,
  input  logic [WIDTH-1:0]             pipe_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_CREDIT_FIFO_STATS_EN
  ,
  output logic [15:0]                  stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(LATENCY+1);
  localparam int UW = ((CW > IW) ? CW : IW) + 1;

  logic [LATENCY-1:0] vld_p;
  logic [IW-1:0]      inflight;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [UW-1:0]      used;
  logic               accept;
  logic               push;
  logic               pop;

  // Credits come from registered state only, so in_ready has no path from in_valid/out_ready.
  assign used      = UW'(count) + UW'(inflight);
  assign in_ready  = used < UW'(DEPTH);
  assign accept    = in_valid & in_ready;
  assign pipe_en   = accept | (inflight != '0);
  assign push      = vld_p[LATENCY-1];
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Stage boundary: valid chain mirroring the upstream delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p    <= '0;
      inflight <= '0;
    end else if (pipe_en) begin
      vld_p    <= (vld_p << 1) | LATENCY'(accept);
      inflight <= inflight + IW'(accept) - IW'(push);
    end
  end

  // Stage boundary: FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef PIPE_CREDIT_FIFO_STATS_EN
  // Saturating count of cycles the producer was held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (in_valid && !in_ready && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Directed bench for pipe_credit_fifo with a behavioural upstream delay line and scoreboard.
module tb_pipe_credit_fifo;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int LATENCY = 4;
  localparam int CW      = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             pipe_en;
  logic [WIDTH-1:0] pipe_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
`ifdef PIPE_CREDIT_FIFO_STATS_EN
  logic [15:0]      stall_cycles;
`endif

  logic [WIDTH-1:0]   din;
  logic [WIDTH-1:0]   dl [LATENCY];
  logic [LATENCY-1:0] dlv;
  logic [WIDTH-1:0]   exp_q [$];

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int mcount = 0;
  int n_acc = 0;
  int n_pop = 0;
  int first_pop = -1;
  int last_pop = 0;
  int sent = 0;
  int c0 = 0;
  logic last_acc;

  pipe_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pipe_en(pipe_en),
    .pipe_data(pipe_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
`ifdef PIPE_CREDIT_FIFO_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Upstream delay line, with a valid tag per stage, advanced by pipe_en.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dlv <= '0;
      for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
    end else if (pipe_en) begin
      dl[0] <= din;
      for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
      dlv <= {dlv[LATENCY-2:0], in_valid & in_ready};
    end
  end
  assign pipe_data = dl[LATENCY-1];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check per-cycle properties, update scoreboard, advance to next negedge.
  task automatic cyc();
    logic acc, pp, push;
    logic [WIDTH-1:0] e;
    #1;
    acc  = in_valid & in_ready;
    pp   = out_valid & out_ready;
    push = dlv[LATENCY-1] & pipe_en;
    chk("count_model", 32'(count), 32'(mcount));
    chk("in_ready_credit", 32'(in_ready), 32'((mcount + $countones(dlv)) < DEPTH));
    chk("pipe_en", 32'(pipe_en), 32'(acc | (dlv != '0)));
    chk("push_while_full", 32'(push && !pp && mcount >= DEPTH), 32'd0);
    if (acc) begin
      exp_q.push_back(din);
      n_acc++;
    end
    if (pp) begin
      n_pop++;
      if (first_pop < 0) first_pop = cyc_n;
      last_pop = cyc_n;
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
    last_acc = acc;
    @(posedge clk);
    mcount += int'(push) - int'(pp);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pipe_en", 32'(pipe_en), 32'd0);
`ifdef PIPE_CREDIT_FIFO_STATS_EN
    chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif
    mcount = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    @(negedge clk);
    do_reset();

    // Single item latency through an empty system.
    in_valid = 1'b1; din = 8'hA5;
    cyc();
    in_valid = 1'b0; din = 8'h00;
    for (int k = 1; k <= LATENCY; k++) begin
      chk("lat_out_valid_early", 32'(out_valid), 32'd0);
      cyc();
    end
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_data", 32'(out_data), 32'hA5);
    cyc();
    chk("lat_drained_pipe_en", 32'(pipe_en), 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("lat_count_after_pop", 32'(count), 32'd0);
    chk("lat_out_valid_after_pop", 32'(out_valid), 32'd0);

    // Fill with consumer stalled.
    n_acc = 0; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = 8'(8'h10 + k);
      cyc();
    end
    chk("fill_accepts", 32'(n_acc), 32'd8);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd8);

    // One pop from full frees exactly one credit.
    out_ready = 1'b1; din = 8'h5A;
    cyc();
    out_ready = 1'b0; n_acc = 0;
    chk("refill_count7", 32'(count), 32'd7);
    chk("refill_in_ready", 32'(in_ready), 32'd1);
    cyc();
    for (int k = 1; k <= LATENCY; k++) begin
      chk("refill_count_wait", 32'(count), 32'd7);
      chk("refill_in_ready_low", 32'(in_ready), 32'd0);
      cyc();
    end
    chk("refill_count8", 32'(count), 32'd8);
    cyc(); cyc();
    chk("refill_one_accept", 32'(n_acc), 32'd1);

    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Streaming 0..19 with both sides enabled.
    in_valid = 1'b1; out_ready = 1'b1; sent = 0; n_pop = 0; first_pop = -1;
    c0 = cyc_n;
    for (int k = 0; k < 40 && sent < 20; k++) begin
      din = 8'(sent);
      cyc();
      if (last_acc) sent++;
    end
    chk("stream_sent", 32'(sent), 32'd20);
    chk("stream_accept_cycles", 32'(cyc_n - c0), 32'd20);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("stream_pops", 32'(n_pop), 32'd20);
    chk("stream_pop_span", 32'(last_pop - first_pop), 32'd19);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;

    // Reset with items both stored and in flight.
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = 8'(8'hC0 + k);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("mid_count_before_rst", 32'(count), 32'd2);
    chk("mid_inflight_before_rst", 32'($countones(dlv)), 32'd3);
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      cyc();
    end
    chk("post_rst_count", 32'(count), 32'd0);
    out_ready = 1'b0;

`ifdef PIPE_CREDIT_FIFO_STATS_EN
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = 8'(k);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("stat_full_in_ready", 32'(in_ready), 32'd0);
    chk("stat_zero", 32'(stall_cycles), 32'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    in_valid = 1'b0;
    chk("stat_five", 32'(stall_cycles), 32'd5);
    in_valid = 1'b1;
    for (int k = 0; k < 65529; k++) cyc();
    in_valid = 1'b0;
    chk("stat_fffe", 32'(stall_cycles), 32'hFFFE);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    in_valid = 1'b0;
    chk("stat_saturate", 32'(stall_cycles), 32'hFFFF);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    chk("stat_drain_count", 32'(count), 32'd0);
    out_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
